store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Load/store interface stage directly upstream of the data memory block (18-bit address, 32-bit data, byteOperations/memRead/memWrite strobes).
- Decouples datapath stores from the single memory port: stores queue in a FIFO and drain one per cycle when the port is idle.
- Loads take priority on the port and are hazard-checked against queued stores, so the program order of memory updates is preserved.

Parameters:
DEPTH, 4, number of store entries; power of two, >= 2
ADDR_W, 18, memory address width
DATA_W, 32, memory data width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
st_valid  in  1  store request
st_ready  out  1  store accepted when st_valid && st_ready
st_addr  in  ADDR_W  store address
st_data  in  DATA_W  store data
st_byte  in  1  1 = byte store (data[7:0] only)
ld_valid  in  1  load request
ld_ready  out  1  load accepted when ld_valid && ld_ready
ld_addr  in  ADDR_W  load address
ld_byte  in  1  1 = byte load, zero-extended
ld_resp_valid  out  1  ld_data valid; one-cycle pulse
ld_data  out  DATA_W  registered load result
mem_address  out  ADDR_W  to memory address
mem_write_data  out  DATA_W  to memory write_data
mem_byteOperations  out  1  to memory byteOperations
mem_memRead  out  1  to memory memRead
mem_memWrite  out  1  to memory memWrite
mem_read_data  in  DATA_W  from memory read_data (combinational)
sb_empty  out  1  no stores pending
sb_count  out  $clog2(DEPTH)+1  entries occupied

Behaviour:
- Reset (async, while high): wr_ptr, rd_ptr and count = 0; ld_resp_valid = 0; ld_data = 0. mem_memRead and mem_memWrite are forced to 0. Mid-operation reset discards all queued stores and any pending response.
- full = (count == DEPTH). st_ready = !full, and does not depend on a same-cycle pop.
- Hazard: a load conflicts if any valid entry has addr == ld_addr (exact 18-bit match).
- ld_ready = !hazard && !full. A full buffer forces a drain, so loads cannot starve stores.
- Port arbitration, per cycle:
  - A load accepted this cycle wins: mem_memRead = 1, mem_address = ld_addr, mem_byteOperations = ld_byte. No drain.
  - Otherwise, if not empty: mem_memWrite = 1 and the head entry drives mem_address, mem_write_data and mem_byteOperations; rd_ptr++ at the edge.
  - Otherwise all strobes are 0; address and data are 0.
- Load response latency is 1: at the edge after acceptance, ld_data <= mem_read_data and ld_resp_valid = 1 for one cycle. The byte zero-extension is done by memory and passed through unchanged.
- A store pushed in the same cycle a load is accepted is ordered after that load. It is not included in that cycle's hazard check.
- A simultaneous push and drain leaves count unchanged. Pointers wrap modulo DEPTH.
- Byte stores write data[7:0] only. mem_write_data carries the full entry; memory masks it.
- Draining continues on consecutive cycles while no load is accepted.

Optional Feature:
- Macro STORE_BUF_FWD_EN.
- Defined: on a hazard, a load is served from the youngest matching entry instead of stalling, and the memory port is not used.
  - A word entry returns the full data for a word load, or {24'b0, data[7:0]} for a byte load.
  - A youngest byte entry with a word load still stalls.
  - Latency stays 1, and ld_ready ignores the hazard except in that stall case.
  - The freed port may drain the head in the same cycle.
- Undefined: a hazard stalls (ld_ready = 0) until all matching entries drain.

Decomposition:
- Package store_buffer_pkg: ADDR_W/DATA_W constants, and typedef sb_entry_t {valid, addr, data, is_byte}.
- Sub-module store_buffer_fifo: circular storage holding pointers and count, with all entries exposed for the address compare.
- Arbitration, hazard logic and the response register stay in the top module.

Test Plan:
- Stores addr 5 = 0xDEADBEEF and addr 6 = 0x12345678 on an idle port → two consecutive mem_memWrite cycles in order; sb_empty = 1 afterwards.
- Push 4 stores without draining (a load each cycle to unrelated addr 100) → after 4 pushes st_ready = 0 and ld_ready = 0; the next cycle drains; count goes 4 → 3.
- Queued store addr 7 = 0xAA, then word load addr 7 → ld_ready = 0 until the drain, then ld_data = 0xAA one cycle after acceptance. With STORE_BUF_FWD_EN: immediate response 0xAA, with no mem_memRead.
- Byte store addr 9 = 0xFFFFFF3C, drain, then byte load addr 9 → ld_data = 0x0000003C.
- Load addr 3 and store addr 3 = 0x55 in the same cycle (memory holds 0x11) → ld_data = 0x11, then the write of 0x55 follows.
- Reset asserted with 3 entries queued → count = 0, no mem_memWrite, ld_resp_valid = 0 immediately and after release.

Source files
------------

// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer_pkg
//  Description : Shared widths and the queued-store entry type for the
//                store buffer placed in front of the data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package store_buffer_pkg;

    // Address and data widths of the data memory port
    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;

    // One queued store
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              is_byte;
    } sb_entry_t;

    // Zero-extend the low byte of a word
    function automatic logic [DATA_W-1:0] zext_byte(input logic [DATA_W-1:0] d);
        return {{(DATA_W-8){1'b0}}, d[7:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer_fifo
//  Description : Circular store queue. Holds the pointers and occupancy count
//                and exposes every entry, oldest first, so the parent can run
//                its address compare and read the head as entries[0].
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [ADDR_W-1:0]       push_addr,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    push_byte,
    input  logic                    pop,
    output sb_entry_t [DEPTH-1:0]   entries,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // Next-state: pop clears the head slot, push fills the tail slot.
    // They never target the same slot: pop needs a non-empty queue and
    // push needs a non-full one.
    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (pop) begin
            entries_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d                  = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            entries_d[wr_ptr_q] = '{valid: 1'b1, addr: push_addr,
                                    data: push_data, is_byte: push_byte};
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state registers; reset discards every queued store
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entries_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Rotate storage so index 0 is the oldest entry (pointers wrap mod DEPTH)
    always_comb begin
        entries = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = entries_q[rd_ptr_q + PTR_W'(i)];
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : Store buffer in front of the single-port data memory.
//                Stores queue and drain one per idle cycle; loads own the
//                port and are hazard-checked against queued stores.
//                Build option STORE_BUF_FWD_EN: serve hazarding loads from
//                the youngest matching entry instead of stalling.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    st_valid,
    output logic                    st_ready,
    input  logic [ADDR_W-1:0]       st_addr,
    input  logic [DATA_W-1:0]       st_data,
    input  logic                    st_byte,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [ADDR_W-1:0]       ld_addr,
    input  logic                    ld_byte,
    output logic                    ld_resp_valid,
    output logic [DATA_W-1:0]       ld_data,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [DATA_W-1:0]       mem_write_data,
    output logic                    mem_byteOperations,
    output logic                    mem_memRead,
    output logic                    mem_memWrite,
    input  logic [DATA_W-1:0]       mem_read_data,
    output logic                    sb_empty,
    output logic [$clog2(DEPTH):0]  sb_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    sb_entry_t [DEPTH-1:0] entries;
    sb_entry_t             head;
    logic [CNT_W-1:0]      count;
    logic                  full, empty;
    logic                  push, pop;
    logic                  ld_accept, port_read, fwd_hit;
    logic                  hazard;
    logic [DEPTH-1:0]      match;
    logic [DATA_W-1:0]     fwd_data;
    logic                  ld_resp_valid_q, ld_resp_valid_d;
    logic [DATA_W-1:0]     ld_data_q, ld_data_d;

    store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_addr (st_addr),
        .push_data (st_data),
        .push_byte (st_byte),
        .pop       (pop),
        .entries   (entries),
        .count     (count)
    );

    assign head  = entries[0];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Exact-address compare of the incoming load against every queued store.
    // A store pushed this cycle is not yet in the queue, so it orders after.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = entries[i].valid && (entries[i].addr == ld_addr);
        end
    end
    assign hazard = |match;

`ifdef STORE_BUF_FWD_EN
    sb_entry_t youngest;
    logic      fwd_stall;

    // Entries are oldest-first, so the last hit in the walk is the youngest
    always_comb begin
        youngest = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i]) youngest = entries[i];
        end
    end

    // A word load cannot be assembled from a byte entry: keep stalling
    assign fwd_stall = hazard && youngest.is_byte && !ld_byte;
    assign ld_ready  = !full && !fwd_stall;
    assign fwd_hit   = ld_accept && hazard;
    assign fwd_data  = ld_byte ? zext_byte(youngest.data) : youngest.data;
`else
    // A full buffer blocks loads so the drain always gets the port
    assign ld_ready  = !full && !hazard;
    assign fwd_hit   = 1'b0;
    assign fwd_data  = '0;
`endif

    assign st_ready  = !full;
    assign push      = st_valid && st_ready;
    assign ld_accept = ld_valid && ld_ready;
    assign port_read = ld_accept && !fwd_hit && !reset;
    assign pop       = !port_read && !empty && !reset;

    // Memory port arbitration: accepted load first, otherwise drain the head
    always_comb begin
        mem_address        = '0;
        mem_write_data     = '0;
        mem_byteOperations = 1'b0;
        mem_memRead        = 1'b0;
        mem_memWrite       = 1'b0;
        if (port_read) begin
            mem_memRead        = 1'b1;
            mem_address        = ld_addr;
            mem_byteOperations = ld_byte;
        end else if (pop) begin
            mem_memWrite       = 1'b1;
            mem_address        = head.addr;
            mem_write_data     = head.data;
            mem_byteOperations = head.is_byte;
        end
    end

    // Load response next-state: one-cycle pulse, data held between loads
    always_comb begin
        ld_resp_valid_d = ld_accept;
        ld_data_d       = ld_data_q;
        if (fwd_hit) begin
            ld_data_d = fwd_data;
        end else if (port_read) begin
            ld_data_d = mem_read_data;
        end
    end

    // Load response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_resp_valid_q <= 1'b0;
            ld_data_q       <= '0;
        end else begin
            ld_resp_valid_q <= ld_resp_valid_d;
            ld_data_q       <= ld_data_d;
        end
    end

    assign ld_resp_valid = ld_resp_valid_q;
    assign ld_data       = ld_data_q;
    assign sb_empty      = empty;
    assign sb_count      = count;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Directed self-checking bench for store_buffer with a small
//                behavioural data memory (combinational read, byte-masked
//                write on the clock edge).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   st_valid, st_ready, st_byte;
    logic [ADDR_W-1:0]      st_addr;
    logic [DATA_W-1:0]      st_data;
    logic                   ld_valid, ld_ready, ld_byte;
    logic [ADDR_W-1:0]      ld_addr;
    logic                   ld_resp_valid;
    logic [DATA_W-1:0]      ld_data;
    logic [ADDR_W-1:0]      mem_address;
    logic [DATA_W-1:0]      mem_write_data;
    logic                   mem_byteOperations, mem_memRead, mem_memWrite;
    logic [DATA_W-1:0]      mem_read_data;
    logic                   sb_empty;
    logic [$clog2(DEPTH):0] sb_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .st_valid           (st_valid),
        .st_ready           (st_ready),
        .st_addr            (st_addr),
        .st_data            (st_data),
        .st_byte            (st_byte),
        .ld_valid           (ld_valid),
        .ld_ready           (ld_ready),
        .ld_addr            (ld_addr),
        .ld_byte            (ld_byte),
        .ld_resp_valid      (ld_resp_valid),
        .ld_data            (ld_data),
        .mem_address        (mem_address),
        .mem_write_data     (mem_write_data),
        .mem_byteOperations (mem_byteOperations),
        .mem_memRead        (mem_memRead),
        .mem_memWrite       (mem_memWrite),
        .mem_read_data      (mem_read_data),
        .sb_empty           (sb_empty),
        .sb_count           (sb_count)
    );

    // Memory model: location 3 holds 0x11, others 0xC0DE00xx
    assign mem_read_data = mem_byteOperations ? {24'h0, mem[mem_address[7:0]][7:0]}
                                              : mem[mem_address[7:0]];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= (i == 3) ? 32'h0000_0011 : (32'hC0DE_0000 | 32'(i));
        end else if (mem_memWrite) begin
            if (mem_byteOperations) mem[mem_address[7:0]][7:0] <= mem_write_data[7:0];
            else                    mem[mem_address[7:0]]      <= mem_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_byte = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_byte = 1'b0;
    endtask

    initial begin
        idle();
        #1 reset = 1'b1;
        #2;
        // ---------------- reset state ----------------
        check("rst_count",    32'(sb_count),      32'd0);
        check("rst_empty",    32'(sb_empty),      32'd1);
        check("rst_resp",     32'(ld_resp_valid), 32'd0);
        check("rst_ld_data",  ld_data,            32'd0);
        check("rst_memwrite", 32'(mem_memWrite),  32'd0);
        check("rst_memread",  32'(mem_memRead),   32'd0);
        check("rst_st_ready", 32'(st_ready),      32'd1);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- two stores drain in order ----------------
        tick();
        st_valid = 1'b1; st_addr = 18'd5; st_data = 32'hDEADBEEF;
        #1;
        check("t1_st_ready",  32'(st_ready),     32'd1);
        check("t1_idle_wr",   32'(mem_memWrite), 32'd0);
        tick();
        st_addr = 18'd6; st_data = 32'h12345678;
        #1;
        check("t1_wr0",       32'(mem_memWrite), 32'd1);
        check("t1_wr0_addr",  32'(mem_address),  32'd5);
        check("t1_wr0_data",  mem_write_data,    32'hDEADBEEF);
        tick();
        idle();
        #1;
        check("t1_count",     32'(sb_count),     32'd1);
        check("t1_wr1",       32'(mem_memWrite), 32'd1);
        check("t1_wr1_addr",  32'(mem_address),  32'd6);
        check("t1_wr1_data",  mem_write_data,    32'h12345678);
        tick();
        #1;
        check("t1_empty",     32'(sb_empty),     32'd1);
        check("t1_no_wr",     32'(mem_memWrite), 32'd0);

        // ---------------- fill while loads hold the port ----------------
        for (int k = 0; k < 4; k++) begin
            st_valid = 1'b1; st_addr = 18'(20 + k); st_data = 32'(k + 1);
            ld_valid = 1'b1; ld_addr = 18'd100; ld_byte = 1'b0;
            #1;
            check("t2_ld_ready", 32'(ld_ready),     32'd1);
            check("t2_rd",       32'(mem_memRead),  32'd1);
            check("t2_no_wr",    32'(mem_memWrite), 32'd0);
            tick();
        end
        check("t2_resp",      32'(ld_resp_valid), 32'd1);
        check("t2_ld_data",   ld_data,            32'hC0DE0064);
        st_valid = 1'b1; st_addr = 18'd30; st_data = 32'h99;
        ld_valid = 1'b1; ld_addr = 18'd100;
        #1;
        check("t2_full_cnt",  32'(sb_count),     32'd4);
        check("t2_st_ready",  32'(st_ready),     32'd0);
        check("t2_ld_stall",  32'(ld_ready),     32'd0);
        check("t2_full_rd",   32'(mem_memRead),  32'd0);
        check("t2_drain",     32'(mem_memWrite), 32'd1);
        check("t2_drain_adr", 32'(mem_address),  32'd20);
        check("t2_drain_dat", mem_write_data,    32'd1);
        tick();
        idle();
        check("t2_cnt3",      32'(sb_count),      32'd3);
        check("t2_no_resp",   32'(ld_resp_valid), 32'd0);
        check("t2_st_ready3", 32'(st_ready),      32'd1);
        for (int k = 1; k < 4; k++) begin
            #1;
            check("t2_order_adr", 32'(mem_address), 32'(20 + k));
            tick();
        end
        check("t2_empty",     32'(sb_empty),     32'd1);

        // ---------------- load hazard on a queued store ----------------
        st_valid = 1'b1; st_addr = 18'd7; st_data = 32'hAA;
        tick();
        idle();
        ld_valid = 1'b1; ld_addr = 18'd7; ld_byte = 1'b0;
        #1;
`ifdef STORE_BUF_FWD_EN
        check("t3_fwd_ready", 32'(ld_ready),     32'd1);
        check("t3_fwd_nord",  32'(mem_memRead),  32'd0);
        check("t3_fwd_drain", 32'(mem_memWrite), 32'd1);
        tick();
        ld_valid = 1'b0;
        check("t3_resp",      32'(ld_resp_valid), 32'd1);
        check("t3_ld_data",   ld_data,            32'hAA);
        check("t3_empty",     32'(sb_empty),      32'd1);
`else
        check("t3_stall",     32'(ld_ready),     32'd0);
        check("t3_drain",     32'(mem_memWrite), 32'd1);
        check("t3_drain_adr", 32'(mem_address),  32'd7);
        tick();
        #1;
        check("t3_ready",     32'(ld_ready),     32'd1);
        check("t3_rd",        32'(mem_memRead),  32'd1);
        check("t3_rd_adr",    32'(mem_address),  32'd7);
        tick();
        ld_valid = 1'b0;
        check("t3_resp",      32'(ld_resp_valid), 32'd1);
        check("t3_ld_data",   ld_data,            32'hAA);
`endif

        // ---------------- byte store then byte load ----------------
        tick();
        st_valid = 1'b1; st_addr = 18'd9; st_data = 32'hFFFFFF3C; st_byte = 1'b1;
        tick();
        idle();
        #1;
        check("t4_wr",        32'(mem_memWrite),       32'd1);
        check("t4_wr_byte",   32'(mem_byteOperations), 32'd1);
        check("t4_wr_data",   mem_write_data,          32'hFFFFFF3C);
        tick();
        ld_valid = 1'b1; ld_addr = 18'd9; ld_byte = 1'b1;
        #1;
        check("t4_ld_ready",  32'(ld_ready),           32'd1);
        check("t4_rd_byte",   32'(mem_byteOperations), 32'd1);
        tick();
        idle();
        check("t4_resp",      32'(ld_resp_valid), 32'd1);
        check("t4_ld_data",   ld_data,            32'h0000003C);
        tick();
        check("t4_pulse",     32'(ld_resp_valid), 32'd0);
        check("t4_hold",      ld_data,            32'h0000003C);

        // ---------------- same-cycle load and store, same address ----------------
        ld_valid = 1'b1; ld_addr = 18'd3; ld_byte = 1'b0;
        st_valid = 1'b1; st_addr = 18'd3; st_data = 32'h55;
        #1;
        check("t5_ld_ready",  32'(ld_ready),     32'd1);
        check("t5_rd",        32'(mem_memRead),  32'd1);
        check("t5_no_wr",     32'(mem_memWrite), 32'd0);
        tick();
        idle();
        #1;
        check("t5_resp",      32'(ld_resp_valid), 32'd1);
        check("t5_ld_data",   ld_data,            32'h11);
        check("t5_wr",        32'(mem_memWrite),  32'd1);
        check("t5_wr_adr",    32'(mem_address),   32'd3);
        check("t5_wr_data",   mem_write_data,     32'h55);
        tick();
        check("t5_mem",       mem[3],             32'h55);

        // ---------------- reset with stores queued ----------------
        for (int k = 0; k < 3; k++) begin
            st_valid = 1'b1; st_addr = 18'(40 + k); st_data = 32'(k);
            ld_valid = 1'b1; ld_addr = 18'd100; ld_byte = 1'b0;
            tick();
        end
        idle();
        check("t6_pre_cnt",   32'(sb_count),      32'd3);
        check("t6_pre_resp",  32'(ld_resp_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_cnt",   32'(sb_count),      32'd0);
        check("t6_rst_wr",    32'(mem_memWrite),  32'd0);
        check("t6_rst_resp",  32'(ld_resp_valid), 32'd0);
        check("t6_rst_empty", 32'(sb_empty),      32'd1);
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_rel_wr",    32'(mem_memWrite),  32'd0);
        check("t6_rel_cnt",   32'(sb_count),      32'd0);
        check("t6_rel_resp",  32'(ld_resp_valid), 32'd0);
        tick();
        check("t6_post_wr",   32'(mem_memWrite),  32'd0);
        check("t6_post_resp", 32'(ld_resp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
